// File: rtl/fp_pkg.sv
// Shared definitions for the sequential single-precision adder: format
// constants, controller state encoding and the unpacked-operand record.
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;
    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        ALIGN  = 3'd2,
        ADD    = 3'd3,
        NORM   = 3'd4,
        DONE   = 3'd5
    } state_e;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   mant;
    } fp_op_t;

    // Split a packed single into sign/exponent/mantissa. The hidden bit is
    // restored for normal numbers; exponent 0 (zero or denormal) yields a
    // zero mantissa, which is how denormal inputs get flushed.
    function automatic fp_op_t fp_unpack(input logic [31:0] v);
        fp_op_t o;
        o.sign = v[31];
        o.exp  = v[30:23];
        o.mant = (v[30:23] != '0) ? {1'b1, v[22:0]} : '0;
        return o;
    endfunction

endpackage

// File: rtl/mant_addsub_24.sv
// 24-bit mantissa adder/subtractor shared by every addition the controller
// performs. Subtraction assumes a >= b, so it never borrows and the carry
// output is forced low.
module mant_addsub_24
    import fp_pkg::*;
(
    input  logic [MAN_W:0] a,
    input  logic [MAN_W:0] b,
    input  logic           sub,
    output logic [MAN_W:0] sum,
    output logic           carry_out
);

    logic [MAN_W+1:0] wide;

    // Single add/subtract with one extra bit to capture the add carry
    always_comb begin
        wide = '0;
        if (sub) begin
            wide = {1'b0, a - b};
        end else begin
            wide = {1'b0, a} + {1'b0, b};
        end
    end

    assign sum       = wide[MAN_W:0];
    assign carry_out = sub ? 1'b0 : wide[MAN_W+1];

endmodule

// File: rtl/fp_add_seq_ctrl.sv
// Multi-cycle IEEE-754 single-precision adder controller. One operation is
// in flight at a time: accept in IDLE, unpack, align, add, normalise one bit
// per cycle, then hold the result in DONE until the consumer takes it.
// Truncating rounding; denormals flush to zero on input and output.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE (and never while rst_n is low);
// out_valid is high only in DONE, and result stays constant while it waits.
module fp_add_seq_ctrl #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);
    import fp_pkg::*;

    state_e           state;
    logic [31:0]      a_r;
    logic [31:0]      b_r;
    logic [31:0]      result_r;
    logic             sign_r;
    logic [EXP_W-1:0] exp_r;
    logic [EXP_W-1:0] shamt;
    logic [MAN_W:0]   man_x;
    logic [MAN_W:0]   man_y;
    logic [MAN_W:0]   sum_r;
    logic             carry_r;
    logic             eff_sub;

    fp_op_t           ua;
    fp_op_t           ub;
    fp_op_t           op_x;
    fp_op_t           op_y;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic             special;
    logic [31:0]      special_res;

    logic [MAN_W:0]   add_sum;
    logic             add_co;

    // Operand classification and magnitude ordering used during UNPACK
    always_comb begin
        ua     = fp_unpack(a_r);
        ub     = fp_unpack(b_r);
        a_nan  = (a_r[30:23] == EXP_MAX) && (a_r[22:0] != '0);
        b_nan  = (b_r[30:23] == EXP_MAX) && (b_r[22:0] != '0);
        a_inf  = (a_r[30:23] == EXP_MAX) && (a_r[22:0] == '0);
        b_inf  = (b_r[30:23] == EXP_MAX) && (b_r[22:0] == '0);
        a_zero = (a_r[30:23] == '0);
        b_zero = (b_r[30:23] == '0);
        special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

        // Larger magnitude goes to X; a tie keeps A as X
        if ({ub.exp, ub.mant} > {ua.exp, ua.mant}) begin
            op_x = ub;
            op_y = ua;
        end else begin
            op_x = ua;
            op_y = ub;
        end

        // Results that bypass the arithmetic path entirely
        if (a_nan || b_nan) begin
            special_res = QNAN;
        end else if (a_inf && b_inf) begin
            special_res = (a_r[31] != b_r[31]) ? QNAN : a_r;
        end else if (a_inf) begin
            special_res = a_r;
        end else if (b_inf) begin
            special_res = b_r;
        end else if (a_zero && b_zero) begin
            special_res = {a_r[31] & b_r[31], 31'h0};
        end else if (a_zero) begin
            special_res = b_r;
        end else begin
            special_res = a_r;
        end
    end

    mant_addsub_24 u_addsub (
        .a         (man_x),
        .b         (man_y),
        .sub       (eff_sub),
        .sum       (add_sum),
        .carry_out (add_co)
    );

    // Controller state machine and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            result_r <= '0;
            sign_r   <= 1'b0;
            exp_r    <= '0;
            shamt    <= '0;
            man_x    <= '0;
            man_y    <= '0;
            sum_r    <= '0;
            carry_r  <= 1'b0;
            eff_sub  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        state <= UNPACK;
                    end
                end
                UNPACK: begin
                    if (special) begin
                        result_r <= special_res;
                        state    <= DONE;
                    end else begin
                        sign_r  <= op_x.sign;
                        exp_r   <= op_x.exp;
                        man_x   <= op_x.mant;
                        man_y   <= op_y.mant;
                        shamt   <= op_x.exp - op_y.exp;
                        eff_sub <= op_x.sign ^ op_y.sign;
                        state   <= ALIGN;
                    end
                end
                ALIGN: begin
                    man_y <= (shamt >= 8'd24) ? '0 : (man_y >> shamt);
                    state <= ADD;
                end
                ADD: begin
                    sum_r   <= add_sum;
                    carry_r <= add_co;
                    state   <= NORM;
                end
                NORM: begin
                    if (carry_r) begin
                        // Carry out: shift right once, which may overflow to Inf
                        carry_r <= 1'b0;
                        if (exp_r == EXP_MAX - 8'd1) begin
                            result_r <= {sign_r, EXP_MAX, 23'h0};
                        end else begin
                            result_r <= {sign_r, exp_r + 8'd1, sum_r[MAN_W:1]};
                        end
                        state <= DONE;
                    end else if (sum_r == '0) begin
                        result_r <= 32'h0;
                        state    <= DONE;
                    end else if (sum_r[MAN_W]) begin
                        result_r <= {sign_r, exp_r, sum_r[MAN_W-1:0]};
                        state    <= DONE;
                    end else if (exp_r == 8'd1) begin
                        // Another shift would leave the normal range: flush
                        result_r <= {sign_r, 31'h0};
                        state    <= DONE;
                    end else begin
                        sum_r <= sum_r << 1;
                        exp_r <= exp_r - 8'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = result_r;

endmodule

// File: tb/tb_fp_add_seq_ctrl.sv
// Bench for fp_add_seq_ctrl: directed cases with known answers, randomized
// operands checked against an arithmetic reference model, backpressure and
// mid-operation reset.
module tb_fp_add_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [31:0] result;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    fp_add_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_in),
        .b         (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    // Clock
    always #5 clk = ~clk;

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: real-valued reasoning on integer mantissas
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output int lat);
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic sx, sy;
        int   ex, ey, mx, my, d, s, k, e;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        a_zero = (a[30:23] == 0);
        b_zero = (b[30:23] == 0);
        lat = 2;
        if (a_nan || b_nan)          r = 32'h7FC0_0000;
        else if (a_inf && b_inf)     r = (a[31] != b[31]) ? 32'h7FC0_0000 : a;
        else if (a_inf)              r = a;
        else if (b_inf)              r = b;
        else if (a_zero && b_zero)   r = {a[31] & b[31], 31'h0};
        else if (a_zero)             r = b;
        else if (b_zero)             r = a;
        else begin
            // Larger magnitude first; for normal numbers the low 31 bits order by magnitude
            if (b[30:0] > a[30:0]) begin
                sx = b[31]; ex = int'(b[30:23]); mx = int'({1'b1, b[22:0]});
                sy = a[31]; ey = int'(a[30:23]); my = int'({1'b1, a[22:0]});
            end else begin
                sx = a[31]; ex = int'(a[30:23]); mx = int'({1'b1, a[22:0]});
                sy = b[31]; ey = int'(b[30:23]); my = int'({1'b1, b[22:0]});
            end
            d  = ex - ey;
            my = (d >= 24) ? 0 : (my / (1 << d));
            s  = (sx == sy) ? (mx + my) : (mx - my);
            if (s == 0) begin
                r   = 32'h0;
                lat = 5;
            end else if (s >= (1 << 24)) begin
                e   = ex + 1;
                r   = (e >= 255) ? {sx, 8'hFF, 23'h0} : {sx, 8'(e), 23'(s / 2)};
                lat = 5;
            end else begin
                k = 0;
                while (s < (1 << 23)) begin
                    s = s * 2;
                    k++;
                end
                if (ex - k < 1) begin
                    r   = {sx, 31'h0};
                    lat = 5 + (ex - 1);
                end else begin
                    r   = {sx, 8'(ex - k), 23'(s)};
                    lat = 5 + k;
                end
            end
        end
    endfunction

    // Random operand, often related to ref_v to hit alignment and cancellation
    function automatic logic [31:0] rand_fp(input logic [31:0] ref_v);
        int          mode;
        int          e;
        logic        s;
        logic [22:0] f;
        mode = int'($urandom_range(0, 99));
        s    = 1'($urandom_range(0, 1));
        f    = 23'($urandom_range(0, 32'h7F_FFFF));
        if (mode < 4)        return {s, 8'h00, 23'h0};
        else if (mode < 7)   return {s, 8'hFF, 23'h0};
        else if (mode < 9)   return {s, 8'hFF, (f | 23'h1)};
        else if (mode < 11)  return {s, 8'h00, (f | 23'h1)};
        else if (mode < 27)  return {~ref_v[31], ref_v[30:23], ref_v[22:0] ^ 23'($urandom_range(0, 255))};
        else if (mode < 37)  return {s, 8'($urandom_range(1, 4)), f};
        else if (mode < 60) begin
            e = int'(ref_v[30:23]) + int'($urandom_range(0, 60)) - 30;
            if (e < 1)   e = 1;
            if (e > 254) e = 254;
            return {s, 8'(e), f};
        end
        return {s, 8'($urandom_range(1, 254)), f};
    endfunction

    // Driver: issue one operation, check latency/result, apply backpressure, retire it
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input int hold, input string tag);
        int lat;
        int w;
        logic [31:0] want;
        @(negedge clk);
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        exp_q.push_back(exp_res);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 100) begin
            lat++;
            @(negedge clk);
            w++;
        end
        want = exp_q.pop_front();
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, result, want);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_result"}, result, want);
            check({tag, "_hold_flags"}, {29'h0, out_valid, in_ready, busy}, 32'b101);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_retired"}, {29'h0, out_valid, in_ready, busy}, 32'b010);
    endtask

    logic [31:0] dir_a   [11] = '{32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h7F7FFFFF,
                                  32'h40400000, 32'h80000000, 32'h3F800000, 32'h7FC00001,
                                  32'h00000000, 32'h3F800000, 32'h00000000};
    logic [31:0] dir_b   [11] = '{32'h3F800000, 32'hBF400000, 32'hFF800000, 32'h7F7FFFFF,
                                  32'hC0400000, 32'h80000000, 32'h30800000, 32'h3F800000,
                                  32'hBF800000, 32'hFF800000, 32'h80000000};
    logic [31:0] dir_res [11] = '{32'h40000000, 32'h3E800000, 32'h7FC00000, 32'h7F800000,
                                  32'h00000000, 32'h80000000, 32'h3F800000, 32'h7FC00000,
                                  32'hBF800000, 32'hFF800000, 32'h00000000};
    int          dir_lat [11] = '{5, 7, 2, 5, 5, 2, 5, 2, 2, 2, 2};

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rr;
        int          rl;

        // Reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_flags", {29'h0, out_valid, in_ready, busy}, 32'b000);
        check("rst_result", result, 32'h0);
        rst_n = 1'b1;
        #1;
        check("rst_release_in_ready", 32'(in_ready), 32'd1);

        // Directed cases with hand-derived answers
        for (int i = 0; i < 11; i++) begin
            run_op(dir_a[i], dir_b[i], dir_res[i], dir_lat[i], 1, $sformatf("dir%0d", i));
        end

        // Backpressure: consumer stalls for 10 cycles
        run_op(32'h3F800000, 32'h3F800000, 32'h40000000, 5, 10, "bp");

        // Reset during NORM aborts the operation
        @(negedge clk);
        a_in     = 32'h3F800000;
        b_in     = 32'hBF400000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_norm_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_flags", {29'h0, out_valid, in_ready, busy}, 32'b000);
        check("abort_result", result, 32'h0);
        rst_n = 1'b1;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        run_op(32'h3F800000, 32'hBF400000, 32'h3E800000, 7, 0, "post_abort");

        // Randomized operands against the reference model
        for (int i = 0; i < 300; i++) begin
            ra = rand_fp({1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)),
                          23'($urandom_range(0, 32'h7F_FFFF))});
            rb = rand_fp(ra);
            if ($urandom_range(0, 1) == 1) begin
                rr = ra;
                ra = rb;
                rb = rr;
            end
            model(ra, rb, rr, rl);
            run_op(ra, rb, rr, rl, int'($urandom_range(0, 2)), $sformatf("rnd%0d_%h_%h", i, ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
